// File: rtl/sdram_arb_pkg.sv
// Shared types and default frame geometry for the SDRAM frame-buffer arbiter.
// Holds the state encoding, the grant encoding and the round-robin helper.
package sdram_arb_pkg;

  localparam int FB_WORDS_DEF  = 384000;  // 800x480 16-bit pixels
  localparam int BURST_LEN_DEF = 8;
  localparam int ADDR_W_DEF    = 24;
  localparam int USE_W_DEF     = 10;
  localparam int RD_URGENT_DEF = 64;
  localparam int RD_LOW_WM_DEF = 256;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARB,
    ST_REFRESH,
    ST_WR_ISSUE,
    ST_RD_ISSUE,
    ST_WAIT
  } state_t;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_t;

  function automatic grant_t other_grant(input grant_t g);
    return (g == GNT_RD) ? GNT_WR : GNT_RD;
  endfunction

endpackage

// File: rtl/sdram_frame_arbiter_if.sv
// Burst command handshake between the arbiter and the SDRAM command engine.
interface sdram_frame_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr,
    input  cmd_ready, cmd_done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr,
    output cmd_ready, cmd_done
  );
endinterface

// File: rtl/frame_addr_ptr.sv
// Burst-granular frame address pointer with wrap at frame end and a
// deferred load that takes effect when an in-flight burst completes.
module frame_addr_ptr
  import sdram_arb_pkg::*;
#(
  parameter int FB_WORDS  = FB_WORDS_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              advance,
  input  logic              load,
  input  logic              inflight,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] END  = ADDR_W'(FB_WORDS);

  logic              pending_reg;
  logic [ADDR_W-1:0] ptr_next;

  assign ptr_next = ptr + STEP;

  always_ff @(posedge clk) begin
    if (srst) begin
      ptr         <= '0;
      wrap        <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (advance) begin
        // A load seen at any point during the burst overrides the advance.
        if (pending_reg || load) begin
          ptr <= '0;
        end else if (ptr_next == END) begin
          ptr  <= '0;
          wrap <= 1'b1;
        end else begin
          ptr <= ptr_next;
        end
        pending_reg <= 1'b0;
      end else if (load) begin
        if (inflight) begin
          pending_reg <= 1'b1;
        end else begin
          ptr <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Burst scheduler in front of the SDRAM command engine: refresh first, then
// urgent reads, then round-robin between eligible write and read bursts.
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int FB_WORDS  = FB_WORDS_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int USE_W     = USE_W_DEF,
  parameter int RD_URGENT = RD_URGENT_DEF,
  parameter int RD_LOW_WM = RD_LOW_WM_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_done,
  input  logic                  ref_req,
  output logic                  ref_ack,
  input  logic                  ref_done,
  input  logic [USE_W-1:0]      wr_use,
  input  logic [USE_W-1:0]      rd_use,
  input  logic                  wr_load,
  input  logic                  rd_load,
  sdram_frame_arbiter_if.master cmd,
  output logic                  wr_frame_done,
  output logic                  busy
);

  localparam logic [USE_W-1:0] URGENT_LVL = USE_W'(RD_URGENT);
  localparam logic [USE_W-1:0] LOW_WM_LVL = USE_W'(RD_LOW_WM);
  localparam logic [USE_W-1:0] BURST_LVL  = USE_W'(BURST_LEN);

  state_t            state_reg;
  grant_t            last_grant_reg;
  logic              rd_en_reg;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              rd_wrap_unused;

  logic   rd_urgent, rd_elig, wr_elig, grant_any;
  grant_t grant_sel;

  always_comb begin
    rd_urgent = rd_en_reg && (rd_use < URGENT_LVL);
    rd_elig   = rd_en_reg && (rd_use < LOW_WM_LVL);
    wr_elig   = (wr_use >= BURST_LVL);
    grant_any = 1'b0;
    grant_sel = GNT_RD;
    if (rd_urgent) begin
      grant_any = 1'b1;
    end else if (rd_elig && wr_elig) begin
      grant_any = 1'b1;
      grant_sel = other_grant(last_grant_reg);
    end else if (rd_elig) begin
      grant_any = 1'b1;
    end else if (wr_elig) begin
      grant_any = 1'b1;
      grant_sel = GNT_WR;
    end
  end

  // last_grant_reg doubles as the owner of the burst in ISSUE/WAIT.
  logic wr_adv, rd_adv, wr_inflight, rd_inflight;
  assign wr_adv      = (state_reg == ST_WAIT) && cmd.cmd_done && (last_grant_reg == GNT_WR);
  assign rd_adv      = (state_reg == ST_WAIT) && cmd.cmd_done && (last_grant_reg == GNT_RD);
  assign wr_inflight = (state_reg == ST_WR_ISSUE) || ((state_reg == ST_WAIT) && (last_grant_reg == GNT_WR));
  assign rd_inflight = (state_reg == ST_RD_ISSUE) || ((state_reg == ST_WAIT) && (last_grant_reg == GNT_RD));

  frame_addr_ptr #(.FB_WORDS(FB_WORDS), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W)) u_wr_ptr (
    .clk      (clk),
    .srst     (rst),
    .advance  (wr_adv),
    .load     (wr_load),
    .inflight (wr_inflight),
    .ptr      (wr_ptr),
    .wrap     (wr_frame_done)
  );

  frame_addr_ptr #(.FB_WORDS(FB_WORDS), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W)) u_rd_ptr (
    .clk      (clk),
    .srst     (rst),
    .advance  (rd_adv),
    .load     (rd_load),
    .inflight (rd_inflight),
    .ptr      (rd_ptr),
    .wrap     (rd_wrap_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_INIT;
      last_grant_reg <= GNT_RD;
      rd_en_reg      <= 1'b0;
      cmd.cmd_valid  <= 1'b0;
      cmd.cmd_write  <= 1'b0;
      cmd.cmd_addr   <= '0;
      ref_ack        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      ref_ack <= 1'b0;
      if (rd_load) rd_en_reg <= 1'b1;
      case (state_reg)
        ST_INIT: begin
          if (init_done) state_reg <= ST_ARB;
        end
        ST_ARB: begin
          if (ref_req) begin
            state_reg <= ST_REFRESH;
            ref_ack   <= 1'b1;
            busy      <= 1'b1;
          end else if (grant_any) begin
            busy           <= 1'b1;
            cmd.cmd_valid  <= 1'b1;
            last_grant_reg <= grant_sel;
            // A load in the grant cycle starts this burst at the frame origin.
            if (grant_sel == GNT_WR) begin
              state_reg    <= ST_WR_ISSUE;
              cmd.cmd_write <= 1'b1;
              cmd.cmd_addr  <= wr_load ? '0 : wr_ptr;
            end else begin
              state_reg    <= ST_RD_ISSUE;
              cmd.cmd_write <= 1'b0;
              cmd.cmd_addr  <= rd_load ? '0 : rd_ptr;
            end
          end
        end
        ST_REFRESH: begin
          if (ref_done) begin
            state_reg <= ST_ARB;
            busy      <= 1'b0;
          end
        end
        ST_WR_ISSUE, ST_RD_ISSUE: begin
          if (cmd.cmd_ready) begin
            cmd.cmd_valid <= 1'b0;
            state_reg     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cmd.cmd_done) begin
            state_reg <= ST_ARB;
            busy      <= 1'b0;
          end
        end
        default: state_reg <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Self-checking bench: table of arbitration vectors plus hand sequences for
// refresh, frame wrap, deferred load and stalled handshakes.
module tb_sdram_frame_arbiter;

  localparam int FB = 128;  // short frame so the wrap is reachable quickly
  localparam int BL = 8;
  localparam int AW = 24;
  localparam int UW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done = 1'b0, ref_req = 1'b0, ref_done = 1'b0;
  logic          wr_load = 1'b0, rd_load = 1'b0;
  logic [UW-1:0] wr_use = '0, rd_use = '0;
  logic          ref_ack, wr_frame_done, busy;

  sdram_frame_arbiter_if #(.ADDR_W(AW)) cmd_bus ();

  sdram_frame_arbiter #(
    .FB_WORDS(FB), .BURST_LEN(BL), .ADDR_W(AW), .USE_W(UW),
    .RD_URGENT(64), .RD_LOW_WM(256)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .ref_req(ref_req),
    .ref_ack(ref_ack), .ref_done(ref_done), .wr_use(wr_use), .rd_use(rd_use),
    .wr_load(wr_load), .rd_load(rd_load), .cmd(cmd_bus),
    .wr_frame_done(wr_frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct { bit write; int addr; bit wfd; } exp_t;
  typedef struct { int rd; int wr; bit write; int addr; int hold; } vec_t;
  exp_t sb[$];
  vec_t vecs[12];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input bit w, input int a, input bit f);
    exp_t e;
    e.write = w; e.addr = a; e.wfd = f;
    sb.push_back(e);
  endtask

  task automatic do_burst(input int hold, input bit raise_ref, input bit load_wr);
    exp_t e;
    bit   got;
    e = sb.pop_front();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (cmd_bus.cmd_valid) got = 1'b1;
      else step;
    end
    check("cmd_valid_seen", got, 1);
    check("cmd_write", cmd_bus.cmd_write, e.write);
    check("cmd_addr", cmd_bus.cmd_addr, e.addr);
    check("busy_in_cmd", busy, 1);
    for (int i = 0; i < hold; i++) begin
      if (raise_ref && i == 0) ref_req = 1'b1;
      step;
      check("stall_valid", cmd_bus.cmd_valid, 1);
      check("stall_addr", cmd_bus.cmd_addr, e.addr);
      check("stall_write", cmd_bus.cmd_write, e.write);
    end
    cmd_bus.cmd_ready = 1'b1;
    step;
    cmd_bus.cmd_ready = 1'b0;
    check("valid_drop", cmd_bus.cmd_valid, 0);
    if (load_wr) wr_load = 1'b1;
    step;
    wr_load = 1'b0;
    cmd_bus.cmd_done = 1'b1;
    step;
    cmd_bus.cmd_done = 1'b0;
    check("wr_frame_done", wr_frame_done, e.wfd);
    check("busy_after_done", busy, 0);
    $display("burst write=%0d addr=%0d hold=%0d wfd=%0d", e.write, e.addr, hold, wr_frame_done);
  endtask

  initial begin
    bit bad, saw_ref, saw_cmd;
    cmd_bus.cmd_ready = 1'b0;
    cmd_bus.cmd_done  = 1'b0;

    vecs[0]  = '{300, 16,  1, 0,  0};
    vecs[1]  = '{200, 16,  0, 0,  0};
    vecs[2]  = '{200, 16,  1, 8,  0};
    vecs[3]  = '{200, 16,  0, 8,  0};
    vecs[4]  = '{200, 16,  1, 16, 0};
    vecs[5]  = '{10,  100, 0, 16, 0};
    vecs[6]  = '{10,  100, 0, 24, 0};
    vecs[7]  = '{10,  100, 0, 32, 0};
    vecs[8]  = '{64,  100, 1, 24, 0};
    vecs[9]  = '{300, 8,   1, 32, 0};
    vecs[10] = '{255, 7,   0, 40, 0};
    vecs[11] = '{300, 50,  1, 40, 5};

    // reset with every request asserted
    wr_use = 100; rd_use = 10; ref_req = 1'b1;
    repeat (3) step;
    check("rst_cmd_valid", cmd_bus.cmd_valid, 0);
    check("rst_cmd_write", cmd_bus.cmd_write, 0);
    check("rst_cmd_addr", cmd_bus.cmd_addr, 0);
    check("rst_ref_ack", ref_ack, 0);
    check("rst_wr_frame_done", wr_frame_done, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step;
      if (cmd_bus.cmd_valid || ref_ack || busy) bad = 1'b1;
    end
    check("init_hold_quiet", bad, 0);

    init_done = 1'b1;
    saw_ref = 1'b0; saw_cmd = 1'b0;
    for (int i = 0; i < 5 && !saw_ref; i++) begin
      step;
      if (ref_ack) saw_ref = 1'b1;
      if (cmd_bus.cmd_valid) saw_cmd = 1'b1;
    end
    check("first_grant_refresh", saw_ref, 1);
    check("no_cmd_before_refresh", saw_cmd, 0);
    ref_req = 1'b0; wr_use = 0; rd_use = 300;
    step;
    check("ref_ack_one_cycle", ref_ack, 0);
    check("busy_in_refresh", busy, 1);
    ref_done = 1'b1;
    step;
    ref_done = 1'b0;
    check("busy_after_refresh", busy, 0);
    $display("init and first refresh done");

    rd_load = 1'b1;
    step;
    rd_load = 1'b0;

    for (int i = 0; i < 12; i++) begin
      rd_use = UW'(vecs[i].rd);
      wr_use = UW'(vecs[i].wr);
      push(vecs[i].write, vecs[i].addr, 1'b0);
      do_burst(vecs[i].hold, 1'b0, 1'b0);
    end

    // refresh requested while a stalled burst is in flight
    rd_use = 300; wr_use = 50;
    push(1'b1, 48, 1'b0);
    do_burst(5, 1'b1, 1'b0);
    step;
    check("refresh_after_burst", ref_ack, 1);
    check("no_cmd_on_refresh", cmd_bus.cmd_valid, 0);
    ref_req = 1'b0; wr_use = 0;
    step;
    ref_done = 1'b1;
    step;
    ref_done = 1'b0;
    $display("refresh after stalled burst done ref_ack_checked");

    // drive the write pointer to the frame end
    wr_use = 100;
    for (int a = 56; a < FB; a += BL) begin
      push(1'b1, a, (a == FB - BL));
      do_burst(0, 1'b0, 1'b0);
    end
    for (int a = 0; a < 40; a += BL) begin
      push(1'b1, a, 1'b0);
      do_burst(0, 1'b0, 1'b0);
    end
    // load during WAIT of the burst at 40
    push(1'b1, 40, 1'b0);
    do_burst(0, 1'b0, 1'b1);
    push(1'b1, 0, 1'b0);
    do_burst(0, 1'b0, 1'b0);

    // load while idle in ARB, then stray cmd_done pulses
    wr_use = 0;
    wr_load = 1'b1;
    step;
    wr_load = 1'b0;
    wr_use = 100;
    push(1'b1, 0, 1'b0);
    do_burst(0, 1'b0, 1'b0);
    push(1'b1, 8, 1'b0);
    do_burst(0, 1'b0, 1'b0);
    wr_use = 0;
    cmd_bus.cmd_done = 1'b1;
    step;
    step;
    cmd_bus.cmd_done = 1'b0;
    wr_use = 100;
    push(1'b1, 16, 1'b0);
    do_burst(0, 1'b0, 1'b0);

    // reset mid-burst
    step;
    check("valid_before_rst", cmd_bus.cmd_valid, 1);
    rst = 1'b1;
    step;
    check("rst_mid_valid", cmd_bus.cmd_valid, 0);
    check("rst_mid_busy", busy, 0);
    $display("reset mid-burst applied");
    rst = 1'b0;
    step;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
